// File: rtl/ideal_springs_stream.sv
`default_nettype none
// ============================================================================
// Module   : ideal_springs_stream
// Purpose  : Snapshots node/ideal/velocity state, streams one saturated
//            spring-damper force per node over valid/ready and reports the
//            negated, saturated sum as the axle reaction force.
//            Optional displacement deadband: define SPRING_DEADBAND_EN.
// Revision : 1.0
// ============================================================================
module ideal_springs_stream #(
   parameter int NUM_NODES     = 8,
   parameter int CONSTANT_SIZE = 5,
   parameter int POSITION_SIZE = 8,
   parameter int VELOCITY_SIZE = 8,
   parameter int FORCE_SIZE    = 7,
   parameter int FORCE_SHIFT   = 0,
   parameter int DEADBAND      = 1,
   localparam int IDX_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1
) (
   input  logic                                                  clk_in,
   input  logic                                                  rst_in,
   input  logic                                                  input_valid,
   output logic                                                  busy,
   input  logic signed [CONSTANT_SIZE-1:0]                       k,
   input  logic signed [CONSTANT_SIZE-1:0]                       b,
   input  logic signed [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0]   nodes,
   input  logic signed [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0]   ideal_nodes,
   input  logic signed [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0]   velocities,
   input  logic signed [1:0][VELOCITY_SIZE-1:0]                  axle_velocity,
   output logic signed [FORCE_SIZE-1:0]                          force_x_out,
   output logic signed [FORCE_SIZE-1:0]                          force_y_out,
   output logic        [IDX_W-1:0]                               force_idx_out,
   output logic                                                  force_out_valid,
   input  logic                                                  force_out_ready,
   output logic signed [FORCE_SIZE-1:0]                          axle_force_x,
   output logic signed [FORCE_SIZE-1:0]                          axle_force_y,
   output logic                                                  output_valid
);

   localparam int DX_W   = POSITION_SIZE + 1;
   localparam int DV_W   = VELOCITY_SIZE + 1;
   localparam int PROD_W = CONSTANT_SIZE + ((DX_W > DV_W) ? DX_W : DV_W);
   localparam int RAW_W  = PROD_W + 1;
   localparam int ACC_W  = FORCE_SIZE + $clog2(NUM_NODES) + 1;
   localparam int NEG_W  = ACC_W + 1;

   localparam logic signed [RAW_W-1:0] F_MAX  = RAW_W'(2 ** (FORCE_SIZE - 1) - 1);
   localparam logic signed [RAW_W-1:0] F_MIN  = RAW_W'(-(2 ** (FORCE_SIZE - 1)));
   localparam logic signed [NEG_W-1:0] A_MAX  = NEG_W'(2 ** (FORCE_SIZE - 1) - 1);
   localparam logic signed [NEG_W-1:0] A_MIN  = NEG_W'(-(2 ** (FORCE_SIZE - 1)));
   localparam logic signed [DX_W-1:0]  DB_POS = DX_W'(DEADBAND);
   localparam logic signed [DX_W-1:0]  DB_NEG = DX_W'(-DEADBAND);
   localparam logic [IDX_W-1:0]        LAST   = IDX_W'(NUM_NODES - 1);

`ifdef SPRING_DEADBAND_EN
   localparam logic DB_EN = 1'b1;
`else
   localparam logic DB_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_EMIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t state_q, state_d;

   logic signed [CONSTANT_SIZE-1:0]                     k_q, b_q;
   logic signed [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0] nodes_q, ideal_q;
   logic signed [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0] vel_q;
   logic signed [1:0][VELOCITY_SIZE-1:0]                axv_q;
   logic        [IDX_W-1:0]                             idx_q, fidx_q;
   logic signed [FORCE_SIZE-1:0]                        fx_q, fy_q, ax_q, ay_q;
   logic signed [ACC_W-1:0]                             acc_q [2];

   logic signed [DX_W-1:0]       dx    [2];
   logic signed [DV_W-1:0]       dv    [2];
   logic signed [RAW_W-1:0]      raw   [2];
   logic signed [FORCE_SIZE-1:0] sat_f [2];
   logic signed [NEG_W-1:0]      neg   [2];
   logic signed [FORCE_SIZE-1:0] sat_a [2];

   // Force for the node at idx_q and the saturated negated running sum.
   always_comb begin
      for (int ax = 0; ax < 2; ax++) begin
         dx[ax] = DX_W'($signed(ideal_q[ax][idx_q])) - DX_W'($signed(nodes_q[ax][idx_q]));
         if (DB_EN && (dx[ax] >= DB_NEG) && (dx[ax] <= DB_POS)) begin
            dx[ax] = '0;
         end
         dv[ax]  = DV_W'($signed(vel_q[ax][idx_q])) - DV_W'($signed(axv_q[ax]));
         raw[ax] = (RAW_W'(k_q) * RAW_W'(dx[ax]) - RAW_W'(b_q) * RAW_W'(dv[ax])) >>> FORCE_SHIFT;
         if (raw[ax] > F_MAX) begin
            sat_f[ax] = F_MAX[FORCE_SIZE-1:0];
         end else if (raw[ax] < F_MIN) begin
            sat_f[ax] = F_MIN[FORCE_SIZE-1:0];
         end else begin
            sat_f[ax] = raw[ax][FORCE_SIZE-1:0];
         end
         neg[ax] = -NEG_W'(acc_q[ax]);
         if (neg[ax] > A_MAX) begin
            sat_a[ax] = A_MAX[FORCE_SIZE-1:0];
         end else if (neg[ax] < A_MIN) begin
            sat_a[ax] = A_MIN[FORCE_SIZE-1:0];
         end else begin
            sat_a[ax] = neg[ax][FORCE_SIZE-1:0];
         end
      end
   end

   always_comb begin
      state_d         = state_q;
      busy            = 1'b1;
      force_out_valid = 1'b0;
      output_valid    = 1'b0;
      case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (input_valid) state_d = S_CALC;
         end
         S_CALC: state_d = S_EMIT;
         S_EMIT: begin
            force_out_valid = 1'b1;
            if (force_out_ready) state_d = (idx_q == LAST) ? S_DONE : S_CALC;
         end
         S_DONE: begin
            output_valid = 1'b1;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         b_q     <= '0;
         nodes_q <= '0;
         ideal_q <= '0;
         vel_q   <= '0;
         axv_q   <= '0;
         idx_q   <= '0;
         fidx_q  <= '0;
         fx_q    <= '0;
         fy_q    <= '0;
         ax_q    <= '0;
         ay_q    <= '0;
         for (int ax = 0; ax < 2; ax++) acc_q[ax] <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: begin
               if (input_valid) begin
                  k_q     <= k;
                  b_q     <= b;
                  nodes_q <= nodes;
                  ideal_q <= ideal_nodes;
                  vel_q   <= velocities;
                  axv_q   <= axle_velocity;
                  idx_q   <= '0;
                  for (int ax = 0; ax < 2; ax++) acc_q[ax] <= '0;
               end
            end
            S_CALC: begin
               fx_q   <= sat_f[0];
               fy_q   <= sat_f[1];
               fidx_q <= idx_q;
               for (int ax = 0; ax < 2; ax++) acc_q[ax] <= acc_q[ax] + ACC_W'(sat_f[ax]);
            end
            S_EMIT: begin
               if (force_out_ready) begin
                  if (idx_q == LAST) begin
                     ax_q <= sat_a[0];
                     ay_q <= sat_a[1];
                  end else begin
                     idx_q <= idx_q + IDX_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign force_x_out   = fx_q;
   assign force_y_out   = fy_q;
   assign force_idx_out = fidx_q;
   assign axle_force_x  = ax_q;
   assign axle_force_y  = ay_q;

endmodule
`default_nettype wire

// File: tb/tb_ideal_springs_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_ideal_springs_stream
// Purpose  : Self-checking bench for ideal_springs_stream (3-node and 1-node
//            instances) against an integer reference model.
// Revision : 1.0
// ============================================================================
module tb_ideal_springs_stream;
   localparam int N  = 3;
   localparam int C  = 5;
   localparam int P  = 8;
   localparam int V  = 8;
   localparam int F  = 7;
   localparam int SH = 0;
   localparam int DB = 1;
   localparam int IW = 2;
`ifdef SPRING_DEADBAND_EN
   localparam bit DB_EN = 1'b1;
`else
   localparam bit DB_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, input_valid, force_out_ready, busy, force_out_valid, output_valid;
   logic signed [C-1:0] k, b;
   logic signed [1:0][N-1:0][P-1:0] nodes, ideal;
   logic signed [1:0][N-1:0][V-1:0] vel;
   logic signed [1:0][V-1:0] axv;
   logic signed [F-1:0] fx, fy, axf, ayf;
   logic [IW-1:0] fidx;

   logic iv1, rdy1, busy1, fv1, ov1;
   logic signed [1:0][0:0][P-1:0] nodes1, ideal1;
   logic signed [1:0][0:0][V-1:0] vel1;
   logic signed [F-1:0] fx1, fy1, ax1, ay1;
   logic [0:0] fidx1;

   assign nodes1 = {nodes[1][0], nodes[0][0]};
   assign ideal1 = {ideal[1][0], ideal[0][0]};
   assign vel1   = {vel[1][0], vel[0][0]};

   ideal_springs_stream #(.NUM_NODES(N), .CONSTANT_SIZE(C), .POSITION_SIZE(P),
      .VELOCITY_SIZE(V), .FORCE_SIZE(F), .FORCE_SHIFT(SH), .DEADBAND(DB)) u_dut (
      .clk_in(clk), .rst_in(rst), .input_valid(input_valid), .busy(busy),
      .k(k), .b(b), .nodes(nodes), .ideal_nodes(ideal), .velocities(vel),
      .axle_velocity(axv), .force_x_out(fx), .force_y_out(fy),
      .force_idx_out(fidx), .force_out_valid(force_out_valid),
      .force_out_ready(force_out_ready), .axle_force_x(axf), .axle_force_y(ayf),
      .output_valid(output_valid));

   ideal_springs_stream #(.NUM_NODES(1), .CONSTANT_SIZE(C), .POSITION_SIZE(P),
      .VELOCITY_SIZE(V), .FORCE_SIZE(F), .FORCE_SHIFT(SH), .DEADBAND(DB)) u_dut1 (
      .clk_in(clk), .rst_in(rst), .input_valid(iv1), .busy(busy1),
      .k(k), .b(b), .nodes(nodes1), .ideal_nodes(ideal1), .velocities(vel1),
      .axle_velocity(axv), .force_x_out(fx1), .force_y_out(fy1),
      .force_idx_out(fidx1), .force_out_valid(fv1),
      .force_out_ready(rdy1), .axle_force_x(ax1), .axle_force_y(ay1),
      .output_valid(ov1));

   int errors = 0;
   int checks = 0;

   // Reference state: [axis][node], axis 0 = x, axis 1 = y.
   int mk, mb;
   int mn [2][N];
   int mi [2][N];
   int mv [2][N];
   int ma [2];
   int ef [2][N];
   int ea [2];

   function automatic int sat(input int v);
      int hi = (1 << (F - 1)) - 1;
      int lo = -(1 << (F - 1));
      return (v > hi) ? hi : ((v < lo) ? lo : v);
   endfunction

   function automatic void build_model(input int n);
      int sum, dx, f;
      for (int ax = 0; ax < 2; ax++) begin
         sum = 0;
         for (int i = 0; i < n; i++) begin
            dx = mi[ax][i] - mn[ax][i];
            if (DB_EN && dx >= -DB && dx <= DB) dx = 0;
            f = (mk * dx - mb * (mv[ax][i] - ma[ax])) >>> SH;
            ef[ax][i] = sat(f);
            sum += ef[ax][i];
         end
         ea[ax] = sat(-sum);
      end
   endfunction

   function automatic void clear_model();
      mk = 0; mb = 0; ma[0] = 0; ma[1] = 0;
      for (int ax = 0; ax < 2; ax++)
         for (int i = 0; i < N; i++) begin
            mn[ax][i] = 0; mi[ax][i] = 0; mv[ax][i] = 0;
         end
   endfunction

   function automatic void case1_positions();
      mi[0][0] = 3;  mi[1][0] = 4;
      mi[0][1] = 6;  mi[1][1] = 8;
      mi[0][2] = 12; mi[1][2] = -2;
      for (int ax = 0; ax < 2; ax++)
         for (int i = 0; i < N; i++) mn[ax][i] = mi[ax][i];
   endfunction

   function automatic void case3_setup();
      clear_model();
      case1_positions();
      mb = 1;
      mv[0][0] = 1;  mv[1][0] = 2;
      mv[0][1] = -2; mv[1][1] = -3;
      mv[0][2] = 5;  mv[1][2] = 8;
   endfunction

   function automatic int srand(input int lo, input int hi);
      return lo + int'($urandom_range(0, hi - lo));
   endfunction

   task automatic load_inputs();
      k = C'(mk);
      b = C'(mb);
      for (int ax = 0; ax < 2; ax++) begin
         axv[ax] = V'(ma[ax]);
         for (int i = 0; i < N; i++) begin
            nodes[ax][i] = P'(mn[ax][i]);
            ideal[ax][i] = P'(mi[ax][i]);
            vel[ax][i]   = V'(mv[ax][i]);
         end
      end
   endtask

   task automatic scramble();
      k = C'($urandom);
      b = C'($urandom);
      for (int ax = 0; ax < 2; ax++) begin
         axv[ax] = V'($urandom);
         for (int i = 0; i < N; i++) begin
            nodes[ax][i] = P'($urandom);
            ideal[ax][i] = P'($urandom);
            vel[ax][i]   = V'($urandom);
         end
      end
   endtask

   // mode 0: ready high (timing checked), 1: random ready, 2: stall beat 1 for 5 cycles
   task automatic run_txn(input int mode, input bit poke);
      int beat, cyc, stall;
      bit got_ov;
      build_model(N);
      load_inputs();
      force_out_ready = 1'b1;
      input_valid = 1'b1;
      @(negedge clk);
      input_valid = 1'b0;
      scramble();
      cyc = 1; beat = 0; stall = 0; got_ov = 1'b0;
      while (!got_ov && cyc < 300) begin
         checks++;
         if (busy !== 1'b1) begin
            errors++; $display("FAIL busy cyc=%0d got %b want 1", cyc, busy);
         end
         if (output_valid === 1'b1) begin
            got_ov = 1'b1;
            checks++;
            if (beat != N) begin
               errors++; $display("FAIL beat_count got %0d want %0d", beat, N);
            end
            checks++;
            if (axf !== F'(ea[0]) || ayf !== F'(ea[1])) begin
               errors++;
               $display("FAIL axle got (%0d,%0d) want (%0d,%0d)", axf, ayf, ea[0], ea[1]);
            end
            if (mode == 0) begin
               checks++;
               if (cyc != 2 * N + 1) begin
                  errors++; $display("FAIL done_latency got %0d want %0d", cyc, 2 * N + 1);
               end
            end
         end else begin
            if (mode == 1) force_out_ready = ($urandom_range(0, 3) != 0);
            else if (mode == 2 && beat == 1 && force_out_valid === 1'b1 && stall < 5) begin
               force_out_ready = 1'b0; stall++;
            end else force_out_ready = 1'b1;
            if (force_out_valid === 1'b1) begin
               checks++;
               if (beat >= N) begin
                  errors++; $display("FAIL extra_beat got beat %0d want at most %0d", beat, N - 1);
               end else begin
                  if (fx !== F'(ef[0][beat]) || fy !== F'(ef[1][beat])) begin
                     errors++;
                     $display("FAIL beat_force idx=%0d got (%0d,%0d) want (%0d,%0d)",
                              beat, fx, fy, ef[0][beat], ef[1][beat]);
                  end
                  checks++;
                  if (fidx !== IW'(beat)) begin
                     errors++; $display("FAIL beat_idx got %0d want %0d", fidx, beat);
                  end
                  if (mode == 0) begin
                     checks++;
                     if (cyc != 2 + 2 * beat) begin
                        errors++;
                        $display("FAIL beat_time idx=%0d got %0d want %0d", beat, cyc, 2 + 2 * beat);
                     end
                  end
               end
               if (force_out_ready) beat++;
            end
            input_valid = poke && (cyc == 3);
            @(negedge clk);
            cyc++;
         end
      end
      input_valid = 1'b0;
      force_out_ready = 1'b1;
      checks++;
      if (!got_ov) begin
         errors++; $display("FAIL timeout got no output_valid want pulse");
      end
      @(negedge clk);
      checks++;
      if (output_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL after_done got ov=%b busy=%b want 0 0", output_valid, busy);
      end
      checks++;
      if (axf !== F'(ea[0]) || ayf !== F'(ea[1])) begin
         errors++; $display("FAIL axle_hold got (%0d,%0d) want (%0d,%0d)", axf, ayf, ea[0], ea[1]);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; input_valid = 1'b0; iv1 = 1'b0; rdy1 = 1'b1; force_out_ready = 1'b1;
      clear_model();
      load_inputs();
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, force_out_valid, output_valid, fx, fy, fidx, axf, ayf} !== '0) begin
         errors++;
         $display("FAIL reset_state got busy=%b v=%b ov=%b f=(%0d,%0d) idx=%0d axle=(%0d,%0d) want 0",
                  busy, force_out_valid, output_valid, fx, fy, fidx, axf, ayf);
      end
      checks++;
      if ({busy1, fv1, ov1, fx1, fy1, fidx1, ax1, ay1} !== '0) begin
         errors++; $display("FAIL reset_state_1node got nonzero outputs want 0");
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_equal_positions();
      clear_model(); mk = 1; case1_positions();
      run_txn(0, 1'b0);
   endtask

   task automatic test_offset_y();
      clear_model(); mk = 1; case1_positions();
      for (int i = 0; i < N; i++) mn[1][i] = mi[1][i] + 1;
      run_txn(0, 1'b0);
   endtask

   task automatic test_damping();
      case3_setup();
      run_txn(0, 1'b0);
   endtask

   task automatic test_saturation();
      clear_model(); mk = 15;
      for (int i = 0; i < N; i++) begin
         mi[0][i] = 100;  mn[0][i] = 0;
         mi[1][i] = -100; mn[1][i] = 20;
      end
      run_txn(0, 1'b0);
   endtask

   task automatic test_single_node();
      int cyc;
      bit got_ov, got_beat;
      clear_model(); mk = 15; mi[0][0] = 100; mn[0][0] = 0; mi[1][0] = 7; mn[1][0] = 5;
      build_model(1);
      load_inputs();
      iv1 = 1'b1;
      @(negedge clk);
      iv1 = 1'b0;
      scramble();
      cyc = 1; got_ov = 1'b0; got_beat = 1'b0;
      while (!got_ov && cyc < 20) begin
         if (fv1 === 1'b1) begin
            got_beat = 1'b1;
            checks++;
            if (fx1 !== F'(ef[0][0]) || fy1 !== F'(ef[1][0]) || fidx1 !== 1'b0 || cyc != 2) begin
               errors++;
               $display("FAIL single_beat cyc=%0d got (%0d,%0d) idx=%0d want (%0d,%0d) idx=0 cyc=2",
                        cyc, fx1, fy1, fidx1, ef[0][0], ef[1][0]);
            end
         end
         if (ov1 === 1'b1) begin
            got_ov = 1'b1;
            checks++;
            if (ax1 !== F'(ea[0]) || ay1 !== F'(ea[1]) || cyc != 3 || !got_beat) begin
               errors++;
               $display("FAIL single_axle cyc=%0d got (%0d,%0d) want (%0d,%0d) cyc=3",
                        cyc, ax1, ay1, ea[0], ea[1]);
            end
         end else begin
            @(negedge clk);
            cyc++;
         end
      end
      checks++;
      if (!got_ov) begin
         errors++; $display("FAIL single_timeout got no output_valid want pulse");
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      case3_setup();
      run_txn(2, 1'b0);
   endtask

   task automatic test_busy_ignore();
      clear_model();
      mk = srand(-16, 15); mb = srand(-16, 15);
      for (int ax = 0; ax < 2; ax++)
         for (int i = 0; i < N; i++) begin
            mn[ax][i] = srand(-128, 127); mi[ax][i] = srand(-128, 127);
            mv[ax][i] = srand(-128, 127);
         end
      run_txn(0, 1'b1);
   endtask

   task automatic test_reset_mid();
      int cyc, ov_seen;
      case3_setup();
      build_model(N);
      load_inputs();
      force_out_ready = 1'b1;
      input_valid = 1'b1;
      @(negedge clk);
      input_valid = 1'b0;
      cyc = 0;
      while (!(force_out_valid === 1'b1 && fidx === IW'(1)) && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (cyc >= 20) begin
         errors++; $display("FAIL reset_mid_wait got no beat 1 want beat 1");
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({busy, force_out_valid, output_valid, fx, fy, fidx, axf, ayf} !== '0) begin
         errors++;
         $display("FAIL reset_mid got busy=%b v=%b ov=%b f=(%0d,%0d) axle=(%0d,%0d) want 0",
                  busy, force_out_valid, output_valid, fx, fy, axf, ayf);
      end
      rst = 1'b0;
      ov_seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (output_valid === 1'b1 || busy === 1'b1) ov_seen++;
      end
      checks++;
      if (ov_seen != 0) begin
         errors++; $display("FAIL reset_mid_quiet got %0d active cycles want 0", ov_seen);
      end
   endtask

   task automatic test_deadband();
      clear_model(); mk = 1;
      for (int i = 0; i < N; i++) begin
         mn[0][i] = srand(-50, 50); mn[1][i] = srand(-50, 50);
      end
      mi[0][0] = mn[0][0] + 1;  mi[1][0] = mn[1][0] - 1;
      mi[0][1] = mn[0][1] - 1;  mi[1][1] = mn[1][1] + 2;
      mi[0][2] = mn[0][2] + 2;  mi[1][2] = mn[1][2];
      run_txn(0, 1'b0);
   endtask

   task automatic test_random();
      for (int t = 0; t < 20; t++) begin
         clear_model();
         mk = srand(-16, 15); mb = srand(-16, 15);
         ma[0] = srand(-128, 127); ma[1] = srand(-128, 127);
         for (int ax = 0; ax < 2; ax++)
            for (int i = 0; i < N; i++) begin
               mn[ax][i] = srand(-128, 127); mi[ax][i] = srand(-128, 127);
               mv[ax][i] = srand(-128, 127);
            end
         run_txn(1, 1'b0);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_equal_positions();
      test_offset_y();
      test_damping();
      test_saturation();
      test_single_node();
      test_backpressure();
      test_busy_ignore();
      test_reset_mid();
      test_deadband();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
